sync_fifo_param: RTL

Next-generation synchronous FIFO: single clock, parametrised width and depth, with programmable almost-full/almost-empty thresholds and a selectable output mode (standard registered read or first-word-fall-through). It also provides an occupancy output and a synchronous flush. It is the drop-in buffer for datapath stages that need back-pressure watermarks rather than fixed flags.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers and types for the parametrised synchronous FIFO.
// Holds address-width sizing, parameter legality checks and the status bundle.
package fifo_pkg;

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
   } fifo_status_t;

   function automatic int fifo_addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic bit fifo_depth_ok(input int depth);
      return (depth >= 2) && ((depth & (depth - 1)) == 0);
   endfunction

   // Watermarks must be reachable occupancies, otherwise the flag is stuck.
   function automatic bit fifo_thresh_ok(input int depth, input int af, input int ae);
      return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
   endfunction

   localparam int FIFO_MIN_DEPTH = 2;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one async read port.
// Contents are intentionally not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [fifo_addr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]              wdata,
   input  logic [fifo_addr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]              rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with programmable watermarks, occupancy output, flush,
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int AF_THRESH  = FIFO_DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter int FWFT       = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [FIFO_WIDTH-1:0]       data_in,
   input  logic                        wr_en,
   input  logic                        rd_en,
   output logic [FIFO_WIDTH-1:0]       data_out,
   output logic                        full,
   output logic                        empty,
   output logic                        almostfull,
   output logic                        almostempty,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        wr_ack,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int AW = fifo_addr_w(FIFO_DEPTH);
   localparam int CW = AW + 1;

   if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: FIFO_DEPTH must be a power of two >= 2");
   end
   if (!fifo_thresh_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
      $error("sync_fifo_param: AF_THRESH or AE_THRESH out of range");
   end

   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [FIFO_WIDTH-1:0] rd_data;
   logic                  rd_acc;
   logic                  wr_acc;
   fifo_status_t          status;

   always_comb begin
      status.full        = (count == CW'(FIFO_DEPTH));
      status.empty       = (count == '0);
      status.almostfull  = (count >= CW'(AF_THRESH));
      status.almostempty = (count <= CW'(AE_THRESH));
   end

   assign full        = status.full;
   assign empty       = status.empty;
   assign almostfull  = status.almostfull;
   assign almostempty = status.almostempty;

   // A read on an empty FIFO never bypasses a same-cycle write.
   assign rd_acc = rd_en && !status.empty;
   assign wr_acc = wr_en && (!status.full || rd_acc);

   fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc && !flush),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_acc && !rd_acc) begin
            count <= count + CW'(1);
         end else if (rd_acc && !wr_acc) begin
            count <= count - CW'(1);
         end
         wr_ack    <= wr_acc;
         overflow  <= wr_en && !wr_acc;
         underflow <= rd_en && !rd_acc;
      end
   end

   if (FWFT != 0) begin : g_fwft
      assign data_out = status.empty ? '0 : rd_data;
   end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_q <= '0;
         end else if (!flush && rd_acc) begin
            dout_q <= rd_data;
         end
      end

      assign data_out = dout_q;
   end

endmodule
